dso_capture_ctrl: RTL and testbench



---
 rtl/dso_capture_pkg.sv | 8 +
 rtl/capture_decim.sv | 28 ++
 rtl/dso_capture_ctrl.sv | 127 ++++++++++++
 tb/tb_dso_capture_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/dso_capture_pkg.sv
// Shared types and default sizing for the DSO capture controller.
package dso_capture_pkg;
    localparam int DEPTH  = 512;
    localparam int ADDR_W = 9;
    localparam int DEC_W  = 4;

    typedef enum logic [2:0] {IDLE, PRE, ARMED, POST, DONE} cap_state_t;
endpackage

// File: rtl/capture_decim.sv
// Sample-rate divider: tick once every 2^decimator clocks while run is high.
module capture_decim #(
    parameter int DEC_W = dso_capture_pkg::DEC_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             run,
    input  logic [DEC_W-1:0] decimator,
    output logic             tick
);
    localparam int CNT_W = 2 ** DEC_W;

    logic [CNT_W-1:0] div_cnt;
    logic [CNT_W-1:0] limit;

    assign limit = (CNT_W'(1) << decimator) - CNT_W'(1);
    assign tick  = run && (div_cnt == limit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            div_cnt <= '0;
        else if (clr)
            div_cnt <= '0;
        else if (run)
            div_cnt <= tick ? '0 : div_cnt + CNT_W'(1);
    end
endmodule

// File: rtl/dso_capture_ctrl.sv
// DSO capture FSM: pre-trigger fill, armed wrap, post-trigger count, done handshake.
// Define CAPTURE_DECIM_EN to enable the decimation divider; otherwise one sample per clock.
module dso_capture_ctrl #(
    parameter int DEPTH  = dso_capture_pkg::DEPTH,
    parameter int ADDR_W = dso_capture_pkg::ADDR_W,
    parameter int DEC_W  = dso_capture_pkg::DEC_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              capture_start,
    input  logic              capture_ack,
    input  logic [ADDR_W-1:0] trig_pos,
    input  logic [DEC_W-1:0]  decimator,
    input  logic              triggered,
    output logic              trig_en,
    output logic              armed,
    output logic              set_capture_done,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [ADDR_W-1:0] trace_end,
    output logic              capture_done
);
    import dso_capture_pkg::*;

    cap_state_t        state, nxt;
    logic [ADDR_W-1:0] tp_q, post_cnt;
    logic [ADDR_W:0]   smpl_cnt, thr;
    logic              tick, active, hit;

    assign active = (state == PRE) || (state == ARMED) || (state == POST);
    assign thr    = (ADDR_W+1)'(DEPTH) - {1'b0, tp_q};
    assign hit    = (state == POST) && (post_cnt == tp_q);

`ifdef CAPTURE_DECIM_EN
    logic [DEC_W-1:0] dec_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            dec_q <= '0;
        else if (state == IDLE && capture_start)
            dec_q <= decimator;
    end

    capture_decim #(.DEC_W(DEC_W)) u_decim (
        .clk       (clk),
        .rst       (rst),
        .clr       (state == IDLE),
        .run       (active),
        .decimator (dec_q),
        .tick      (tick)
    );
`else
    logic unused_dec;
    assign unused_dec = ^decimator;
    assign tick       = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= nxt;
    end

    always_comb begin
        nxt              = state;
        trig_en          = 1'b0;
        armed            = 1'b0;
        set_capture_done = 1'b0;
        we               = 1'b0;
        capture_done     = 1'b0;
        case (state)
            IDLE: if (capture_start) nxt = PRE;
            PRE: begin
                trig_en = 1'b1;
                we      = tick;
                if (smpl_cnt >= thr) nxt = ARMED;
            end
            ARMED: begin
                trig_en = 1'b1;
                armed   = 1'b1;
                we      = tick;
                if (triggered) nxt = POST;
            end
            POST: begin
                trig_en = 1'b1;
                // The closing cycle never writes, even if it carries a tick.
                if (hit) begin
                    set_capture_done = 1'b1;
                    nxt              = DONE;
                end else begin
                    we = tick;
                end
            end
            DONE: begin
                capture_done = 1'b1;
                if (capture_ack) nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            waddr     <= '0;
            smpl_cnt  <= '0;
            post_cnt  <= '0;
            tp_q      <= '0;
            trace_end <= '0;
        end else if (state == IDLE) begin
            waddr    <= '0;
            smpl_cnt <= '0;
            post_cnt <= '0;
            if (capture_start) tp_q <= trig_pos;
        end else begin
            if (we) begin
                waddr <= waddr + ADDR_W'(1);
                if (smpl_cnt != (ADDR_W+1)'(DEPTH)) smpl_cnt <= smpl_cnt + (ADDR_W+1)'(1);
            end
            if (state == ARMED)
                post_cnt <= '0;
            else if (state == POST && we)
                post_cnt <= post_cnt + ADDR_W'(1);
            if (set_capture_done) trace_end <= waddr - ADDR_W'(1);
        end
    end
endmodule

// File: tb/tb_dso_capture_ctrl.sv
// Scoreboard bench for dso_capture_ctrl: expected write addresses queued per scenario.
module tb_dso_capture_ctrl;
    localparam int DEPTH  = 512;
    localparam int ADDR_W = 9;
    localparam int DEC_W  = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              capture_start = 1'b0;
    logic              capture_ack = 1'b0;
    logic [ADDR_W-1:0] trig_pos = '0;
    logic [DEC_W-1:0]  decimator = '0;
    logic              triggered = 1'b0;
    logic              trig_en, armed, set_capture_done, we, capture_done;
    logic [ADDR_W-1:0] waddr, trace_end;

    int total = 0;
    int bad   = 0;
    int exp_q[$];

    dso_capture_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DEC_W(DEC_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .capture_start    (capture_start),
        .capture_ack      (capture_ack),
        .trig_pos         (trig_pos),
        .decimator        (decimator),
        .triggered        (triggered),
        .trig_en          (trig_en),
        .armed            (armed),
        .set_capture_done (set_capture_done),
        .we               (we),
        .waddr            (waddr),
        .trace_end        (trace_end),
        .capture_done     (capture_done)
    );

    always #5 clk = ~clk;

    // Write monitor: every strobe must match the next queued address.
    always @(posedge clk) begin
        int e;
        #1;
        if (!rst && we === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL wr_unexpected waddr=%0d required=no write", waddr);
            end else begin
                e = exp_q.pop_front();
                if (waddr !== ADDR_W'(e)) begin
                    bad++;
                    $display("FAIL wr_addr got=%0d exp=%0d", waddr, e);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #12;
        total++; if (trig_en !== 1'b0)          begin bad++; $display("FAIL rst_trig_en got=%b exp=0", trig_en); end
        total++; if (armed !== 1'b0)            begin bad++; $display("FAIL rst_armed got=%b exp=0", armed); end
        total++; if (set_capture_done !== 1'b0) begin bad++; $display("FAIL rst_scd got=%b exp=0", set_capture_done); end
        total++; if (we !== 1'b0)               begin bad++; $display("FAIL rst_we got=%b exp=0", we); end
        total++; if (capture_done !== 1'b0)     begin bad++; $display("FAIL rst_done got=%b exp=0", capture_done); end
        total++; if (waddr !== '0)              begin bad++; $display("FAIL rst_waddr got=%0d exp=0", waddr); end
        total++; if (trace_end !== '0)          begin bad++; $display("FAIL rst_trace_end got=%0d exp=0", trace_end); end
        rst = 1'b0;
        step();
    endtask

    // Full capture with decimator=0; triggered is sampled at the end of cycle trig_at.
    task automatic do_capture(input int tp, input int trig_at, input string nm);
        int arm_cyc, done_cyc, nwr;
        arm_cyc  = (tp == 0) ? DEPTH + 2 : DEPTH - tp + 2;
        done_cyc = trig_at + 1 + tp;
        nwr      = trig_at + tp;
        for (int i = 0; i < nwr; i++) exp_q.push_back(i % DEPTH);
        trig_pos      = ADDR_W'(tp);
        decimator     = '0;
        capture_start = 1'b1;
        step();
        capture_start = 1'b0;
        trig_pos      = ADDR_W'(3);
        for (int c = 1; c <= done_cyc + 1; c++) begin
            total++;
            if (armed !== (c >= arm_cyc && c <= trig_at)) begin
                bad++; $display("FAIL %s_armed cyc=%0d got=%b exp=%b", nm, c, armed, (c >= arm_cyc && c <= trig_at));
            end
            total++;
            if (set_capture_done !== (c == done_cyc)) begin
                bad++; $display("FAIL %s_scd cyc=%0d got=%b exp=%b", nm, c, set_capture_done, (c == done_cyc));
            end
            total++;
            if (capture_done !== (c > done_cyc)) begin
                bad++; $display("FAIL %s_done cyc=%0d got=%b exp=%b", nm, c, capture_done, (c > done_cyc));
            end
            total++;
            if (trig_en !== (c <= done_cyc)) begin
                bad++; $display("FAIL %s_trig_en cyc=%0d got=%b exp=%b", nm, c, trig_en, (c <= done_cyc));
            end
            // Spurious inputs: trigger in PRE, ack outside DONE, start while armed.
            triggered     = (c == trig_at) || (c == 2 && arm_cyc > 4);
            capture_ack   = (c == 3);
            capture_start = (c == arm_cyc + 1) && (trig_at > arm_cyc + 1);
            if (c <= done_cyc) step();
        end
        triggered = 1'b0; capture_ack = 1'b0; capture_start = 1'b0;
        total++;
        if (trace_end !== ADDR_W'((nwr - 1) % DEPTH)) begin
            bad++; $display("FAIL %s_trace_end got=%0d exp=%0d", nm, trace_end, (nwr - 1) % DEPTH);
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++; $display("FAIL %s_writes_missing got=%0d exp=0", nm, exp_q.size());
            exp_q.delete();
        end
        capture_ack = 1'b1;
        step();
        capture_ack = 1'b0;
        total++;
        if (capture_done !== 1'b0 || trig_en !== 1'b0) begin
            bad++; $display("FAIL %s_ack got=%b%b exp=00", nm, capture_done, trig_en);
        end
        step();
    endtask

    task automatic test_normal();      do_capture(256, 300, "normal");  endtask
    task automatic test_edge_tp();     do_capture(0, 520, "tp0");  do_capture(511, 5, "tp511"); endtask
    task automatic test_wrap();        do_capture(10, 1504, "wrap");    endtask

    task automatic test_reset_post();
        for (int i = 0; i < 450; i++) exp_q.push_back(i);
        trig_pos      = ADDR_W'(100);
        capture_start = 1'b1;
        step();
        capture_start = 1'b0;
        for (int c = 1; c < 450; c++) begin
            triggered = (c == 420);
            step();
        end
        triggered = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        total++;
        if ({trig_en, armed, set_capture_done, we, capture_done} !== 5'b0 || waddr !== '0) begin
            bad++; $display("FAIL rstpost_outputs got=%b%b%b%b%b/%0d exp=00000/0",
                            trig_en, armed, set_capture_done, we, capture_done, waddr);
        end
        step();
        total++;
        if (set_capture_done !== 1'b0 || capture_done !== 1'b0) begin
            bad++; $display("FAIL rstpost_no_done got=%b%b exp=00", set_capture_done, capture_done);
        end
        rst = 1'b0;
        total++;
        if (exp_q.size() != 0) begin
            bad++; $display("FAIL rstpost_writes got=%0d exp=0", exp_q.size());
            exp_q.delete();
        end
        step();
        do_capture(511, 5, "after_rst");
    endtask

    task automatic test_decim();
        logic exp_we;
`ifdef CAPTURE_DECIM_EN
        for (int i = 0; i < 4; i++) exp_q.push_back(i);
`else
        for (int i = 0; i < 16; i++) exp_q.push_back(i);
`endif
        trig_pos      = ADDR_W'(511);
        decimator     = DEC_W'(2);
        capture_start = 1'b1;
        step();
        capture_start = 1'b0;
        for (int c = 1; c <= 16; c++) begin
`ifdef CAPTURE_DECIM_EN
            exp_we = (c % 4 == 0);
`else
            exp_we = 1'b1;
`endif
            total++;
            if (we !== exp_we) begin
                bad++; $display("FAIL decim_we cyc=%0d got=%b exp=%b", c, we, exp_we);
            end
            if (c < 16) step();
        end
        #1;
        rst = 1'b1;
        #1;
        rst = 1'b0;
        decimator = '0;
        total++;
        if (exp_q.size() != 0) begin
            bad++; $display("FAIL decim_writes got=%0d exp=0", exp_q.size());
            exp_q.delete();
        end
        step();
    endtask

    initial begin
        test_reset();
        test_normal();
        test_edge_tp();
        test_wrap();
        test_reset_post();
        test_decim();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
